// File: rtl/ct_ifu_bht_pre_array_spec_if.sv
// BHT predictor array access bundle: index, chip/write enables,
// per-bit write mask, write data and the registered read data.
interface ct_ifu_bht_pre_array_spec_if;
  logic [9:0]  bht_pred_array_index;
  logic        bht_pred_array_cen_b;
  logic        bht_pred_array_gwen;
  logic [63:0] bht_pred_bwen;
  logic [63:0] bht_pred_array_din;
  logic [63:0] bht_pre_data_out;

  modport master (
    output bht_pred_array_index,
    output bht_pred_array_cen_b,
    output bht_pred_array_gwen,
    output bht_pred_bwen,
    output bht_pred_array_din,
    input  bht_pre_data_out
  );

  modport slave (
    input  bht_pred_array_index,
    input  bht_pred_array_cen_b,
    input  bht_pred_array_gwen,
    input  bht_pred_bwen,
    input  bht_pred_array_din,
    output bht_pre_data_out
  );
endinterface

// File: rtl/ct_ifu_bht_pre_array_spec.sv
// BHT predictor array: 1024 x 64 bit-maskable RAM with 1-cycle registered read.
// Ports: forever_cpuclk, cpurst (sync, active-high), clock-gate controls, arr (slave bundle).
module ct_ifu_bht_pre_array_spec (
  input  logic forever_cpuclk,
  input  logic cpurst,
  input  logic bht_pre_array_clk_en,
  input  logic cp0_yy_clk_en,
  input  logic cp0_ifu_icg_en,
  input  logic pad_yy_icg_scan_en,
  ct_ifu_bht_pre_array_spec_if.slave arr
);

  logic        gate_en;
  logic        gate_en_lat;
  logic [63:0] mem [1024];
  logic [63:0] data_q;
  logic        acc;
  logic        wr;
  logic        rd;

  assign gate_en = (cp0_yy_clk_en
                 & (cp0_ifu_icg_en | bht_pre_array_clk_en))
                 | pad_yy_icg_scan_en;

  // ICG latch: transparent while the clock is low, so the enable
  // seen at the rising edge cannot glitch during the high phase.
  always_latch begin
    if (!forever_cpuclk)
      gate_en_lat <= gate_en;
  end

  assign acc = gate_en_lat & ~arr.bht_pred_array_cen_b;
  assign wr  = acc & ~arr.bht_pred_array_gwen;
  assign rd  = acc &  arr.bht_pred_array_gwen;

  // Reset runs on the free-running clock so it clears the array
  // even while the gated clock is off.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= '0;
      data_q <= '0;
    end else begin
      if (wr)
        mem[arr.bht_pred_array_index] <=
          (mem[arr.bht_pred_array_index] & arr.bht_pred_bwen)
          | (arr.bht_pred_array_din & ~arr.bht_pred_bwen);
      if (rd)
        data_q <= mem[arr.bht_pred_array_index];
    end
  end

  assign arr.bht_pre_data_out = data_q;

endmodule

// File: tb/tb_ct_ifu_bht_pre_array_spec.sv
// Directed bench for the BHT predictor array: vector table plus
// hand-written sequences for clock gating and reset corners.
module tb_ct_ifu_bht_pre_array_spec;

  logic clk;
  logic rst;
  logic clk_en;
  logic yy_en;
  logic icg_en;
  logic scan_en;

  ct_ifu_bht_pre_array_spec_if bus ();

  ct_ifu_bht_pre_array_spec dut (
    .forever_cpuclk       (clk),
    .cpurst               (rst),
    .bht_pre_array_clk_en (clk_en),
    .cp0_yy_clk_en        (yy_en),
    .cp0_ifu_icg_en       (icg_en),
    .pad_yy_icg_scan_en   (scan_en),
    .arr                  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        cen_b;
    logic        gwen;
    logic [9:0]  idx;
    logic [63:0] din;
    logic [63:0] bwen;
    bit          chk;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   nvec;
  int   nerr;

  function automatic void add(string n, logic c, logic g,
                              logic [9:0] i, logic [63:0] d,
                              logic [63:0] b, bit k, logic [63:0] e);
    vec_t v;
    v.name = n; v.cen_b = c; v.gwen = g; v.idx = i;
    v.din = d; v.bwen = b; v.chk = k; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic c, logic g, logic [9:0] i,
                       logic [63:0] d, logic [63:0] b);
    bus.bht_pred_array_cen_b = c;
    bus.bht_pred_array_gwen  = g;
    bus.bht_pred_array_index = i;
    bus.bht_pred_array_din   = d;
    bus.bht_pred_bwen        = b;
  endtask

  task automatic check(string n, logic [63:0] exp);
    nvec++;
    if (bus.bht_pre_data_out !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               n, bus.bht_pre_data_out, exp);
    end
  endtask

  task automatic wr(logic [9:0] i, logic [63:0] d);
    drive(1'b0, 1'b0, i, d, 64'h0);
    step();
  endtask

  task automatic rd(logic [9:0] i);
    drive(1'b0, 1'b1, i, 64'h0, 64'h0);
    step();
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 10'h0, 64'h0, '1);
  endtask

  task automatic set_gate(logic y, logic c, logic g, logic s);
    yy_en = y; clk_en = c; icg_en = g; scan_en = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [63:0] bw;
  logic [63:0] ex;

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b1;
    set_gate(1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    step();
    step();
    rst = 1'b0;
    check("reset_out", 64'h0);

    for (int i = 1; i <= 9; i++)
      add("wr_basic", 1'b0, 1'b0, 10'(i), 64'(i), 64'h0, 1'b0, 64'h0);
    for (int i = 1; i <= 9; i++)
      add("rd_basic", 1'b0, 1'b1, 10'(i), 64'h0, 64'h0, 1'b1, 64'(i));
    for (int i = 10; i <= 14; i++)
      add("cen_hold", 1'b1, 1'b0, 10'(i), 64'h2, 64'h0, 1'b1, 64'h9);
    add("cen_nowr", 1'b0, 1'b1, 10'd10, 64'h0, 64'h0, 1'b1, 64'h0);
    add("wr_last", 1'b0, 1'b0, 10'h3ff, '1, 64'h0, 1'b1, 64'h0);
    add("rd_last", 1'b0, 1'b1, 10'h3ff, 64'h0, 64'h0, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFF);

    foreach (vecs[k]) begin
      drive(vecs[k].cen_b, vecs[k].gwen, vecs[k].idx,
            vecs[k].din, vecs[k].bwen);
      step();
      if (vecs[k].chk)
        check(vecs[k].name, vecs[k].exp);
    end

    for (int i = 0; i < 32; i++) begin
      bw = 64'hFFFF_FFFF_FFFF_FFFC << (2 * i);
      drive(1'b0, 1'b0, 10'h0, '1, bw);
      step();
      rd(10'h0);
      ex = (i == 31) ? '1 : ((64'd1 << (2 * i + 2)) - 64'd1);
      check("bitmask", ex);
    end

    wr(10'h000, 64'hBB);
    wr(10'h200, 64'hAA);
    rd(10'h200);
    check("alias_200", 64'hAA);
    rd(10'h000);
    check("alias_000", 64'hBB);
    rd(10'h3ff);
    check("alias_3ff", 64'hFFFF_FFFF_FFFF_FFFF);

    do_reset();
    idle();
    step();
    check("reset2_out", 64'h0);
    rd(10'd3);
    check("reset2_mem", 64'h0);

    set_gate(1'b1, 1'b0, 1'b0, 1'b0);
    wr(10'd5, 64'h55);
    rd(10'd5);
    check("gated_hold", 64'h0);
    set_gate(1'b1, 1'b1, 1'b0, 1'b0);
    rd(10'd5);
    check("gated_nowr", 64'h0);

    set_gate(1'b1, 1'b0, 1'b1, 1'b0);
    wr(10'd5, 64'h55);
    rd(10'd5);
    check("icg_force", 64'h55);

    set_gate(1'b0, 1'b0, 1'b0, 1'b1);
    wr(10'd6, 64'h66);
    rd(10'd6);
    check("scan_force", 64'h66);

    set_gate(1'b0, 1'b1, 1'b1, 1'b0);
    wr(10'd7, 64'h77);
    set_gate(1'b1, 1'b1, 1'b0, 1'b0);
    rd(10'd7);
    check("global_off", 64'h0);

    rd(10'd5);
    check("pre_rst_rd", 64'h55);
    set_gate(1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    do_reset();
    step();
    check("rst_gated", 64'h0);
    set_gate(1'b1, 1'b1, 1'b0, 1'b0);
    rd(10'd6);
    check("rst_gated_mem", 64'h0);

    rst = 1'b1;
    drive(1'b0, 1'b0, 10'd8, 64'h99, 64'h0);
    step();
    rst = 1'b0;
    rd(10'd8);
    check("rst_prio", 64'h0);

    wr(10'd9, 64'h1234);
    rd(10'd9);
    rd(10'd8);
    check("stream_rd", 64'h0);

    idle();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
